// File: rtl/apb_cmd_sequencer.sv
// Purpose     : APB master that runs a queued stream of write / read / read-compare /
// Latency     : cmd into an empty FIFO -> PSEL +2, PENABLE +3, o_rsp_valid +4 (PREADY=1); +1 per wait state
// Backpressure: o_cmd_ready drops while DEPTH entries are queued; o_rsp_valid is never stalled
//
//   wait-for-interrupt commands against a register-block slave, with wait-state
//   handling, PSLVERR capture, masked compare, interrupt waits and a timeout.
// Ports:
//   i_pclk / i_prst_n                    clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready / i_cmd_*  command push interface (op, addr, data, mask)
//   o_paddr .. o_penable, i_prdata ..    APB master signals
//   i_int                                level interrupt awaited by op 11
//   i_clr_status                         clears o_timeout and o_mismatch_cnt
//   o_rsp_valid / o_rsp_data / o_rsp_err one-cycle completion report per command
//   o_busy / o_timeout / o_mismatch_cnt  activity and sticky status
module apb_cmd_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              i_pclk,
  input  logic              i_prst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  input  logic [DATA_W-1:0] i_cmd_mask,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  output logic              o_pwrite,
  output logic              o_psel,
  output logic              o_penable,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr,
  input  logic              i_int,
  input  logic              i_clr_status,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [15:0]       o_mismatch_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wait counter must be able to hold TIMEOUT itself; keep one bit when disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_CMP  = 2'b10;
  localparam logic [1:0] OP_WINT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT_INT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } cmd_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  cmd_t             push_cmd;
  cmd_t             head;
  logic             push, pop;

  state_e           state_q, state_d;

  assign push_cmd = {i_cmd_op, i_cmd_addr, i_cmd_data, i_cmd_mask};
  assign head     = mem_q[rd_ptr_q];

  // Ready comes from the registered count only, so a pop frees a slot for the
  // producer one cycle later. Held low while reset is asserted.
  assign o_cmd_ready = i_prst_n & (count_q < FULL_CNT);
  assign push        = i_cmd_valid & o_cmd_ready;
  assign pop         = (state_q == S_IDLE) & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_pclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_cmd;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command registers and APB address/data phase signals
  // ---------------------------------------------------------------------------
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q, mask_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              pwrite_q;

  // APB fields are only reloaded for bus commands, so they keep their last
  // value through idle periods and interrupt waits.
  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      op_q     <= OP_WR;
      data_q   <= '0;
      mask_q   <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else if (pop) begin
      op_q   <= head.op;
      data_q <= head.data;
      mask_q <= head.mask;
      if (head.op != OP_WINT) begin
        paddr_q  <= head.addr;
        pwdata_q <= head.data;
        pwrite_q <= (head.op == OP_WR);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  wcnt_q, wcnt_d, wcnt_inc;
  logic              to_hit;
  logic              mismatch_now;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              mismatch_q, mismatch_d;
  logic              to_evt;

  assign wcnt_inc = wcnt_q + CNT_W'(1);
  // Fires on the cycle whose increment would make the counter reach TIMEOUT,
  // i.e. after exactly TIMEOUT cycles spent waiting.
  assign to_hit   = (TIMEOUT != 0) && (wcnt_inc == TO_VAL);
  assign mismatch_now = (op_q == OP_CMP) & (|((i_prdata ^ data_q) & mask_q));

  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mismatch_d = mismatch_q;
    to_evt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = (head.op == OP_WINT) ? S_WAIT_INT : S_SETUP;
          wcnt_d  = '0;
        end
      end

      S_SETUP: begin
        state_d = S_ACCESS;
        wcnt_d  = '0;
      end

      S_ACCESS: begin
        if (i_pready) begin
          state_d    = S_RESP;
          rsp_data_d = (op_q == OP_WR) ? '0 : i_prdata;
          mismatch_d = mismatch_now;
          rsp_err_d  = i_pslverr | mismatch_now;
        end else if (to_hit) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          mismatch_d = 1'b0;
          rsp_err_d  = 1'b1;
          to_evt     = 1'b1;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end

      S_WAIT_INT: begin
        if (i_int) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          mismatch_d = 1'b0;
          rsp_err_d  = 1'b0;
        end else if (to_hit) begin
          state_d    = S_RESP;
          rsp_data_d = '0;
          mismatch_d = 1'b0;
          rsp_err_d  = 1'b1;
          to_evt     = 1'b1;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky status; a clear request wins over a same-cycle update
  // ---------------------------------------------------------------------------
  logic        timeout_q;
  logic [15:0] mm_cnt_q;

  always_ff @(posedge i_pclk or negedge i_prst_n) begin
    if (!i_prst_n) begin
      timeout_q <= 1'b0;
      mm_cnt_q  <= '0;
    end else if (i_clr_status) begin
      timeout_q <= 1'b0;
      mm_cnt_q  <= '0;
    end else begin
      if (to_evt) timeout_q <= 1'b1;
      if ((state_q == S_RESP) && mismatch_q && (mm_cnt_q != 16'hFFFF)) begin
        mm_cnt_q <= mm_cnt_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // PSEL/PENABLE decode straight from the state register, so reset drops them
  // without waiting for a clock edge.
  assign o_psel         = (state_q == S_SETUP) | (state_q == S_ACCESS);
  assign o_penable      = (state_q == S_ACCESS);
  assign o_paddr        = paddr_q;
  assign o_pwdata       = pwdata_q;
  assign o_pwrite       = pwrite_q;
  assign o_rsp_valid    = (state_q == S_RESP);
  assign o_rsp_data     = rsp_data_q;
  assign o_rsp_err      = rsp_err_q;
  assign o_busy         = (state_q != S_IDLE) | (count_q != '0);
  assign o_timeout      = timeout_q;
  assign o_mismatch_cnt = mm_cnt_q;

  // Plain reads share the capture path with compares but never flag a mismatch.
  logic unused_op_rd;
  assign unused_op_rd = (op_q == OP_RD);

endmodule
